// File: rtl/ysyx_22041752_iter_div.sv
// ----------------------------------------------------------------------------
// ysyx_22041752_iter_div
//
// Multi-cycle radix-2 restoring divider that sits behind the ALU's
// op_div/op_rem path. One request produces both the quotient and the remainder.
// Requests and results each use a valid/ready handshake. The execute stage
// stalls until out_valid is high, and a pipeline flush drops any work in
// flight.
//
// Optional feature macro: YSYX_22041752_DIV_WORD_EN
//   defined   : RV64 word ops (DIVW/DIVUW/REMW/REMUW) are honoured when
//               WIDTH == 64. They run in 32 iterations, and both results are
//               sign-extended from bit 31.
//   undefined : the word input is ignored, and every op takes WIDTH
//               iterations.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   flush       synchronous abort; returns to IDLE on the next edge
//   in_valid    request valid
//   in_ready    divider idle (high only in IDLE)
//   div_signed  1 = signed DIV/REM, 0 = unsigned (sampled at handshake)
//   word        1 = 32-bit op (sampled at handshake, see macro above)
//   dividend    numerator   [WIDTH]
//   divisor     denominator [WIDTH]
//   out_valid   result valid (high only in DONE)
//   out_ready   consumer accepts the result
//   quotient    registered quotient  [WIDTH]
//   remainder   registered remainder [WIDTH]
//
// Latency: a handshake in cycle 0 gives out_valid in cycle N+1, where N is 32
// for word ops and WIDTH otherwise. Divide-by-zero and signed overflow finish
// in cycle 1.
// ----------------------------------------------------------------------------
module ysyx_22041752_iter_div #(
  parameter int WIDTH = 64  // even, >= 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic             word,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter must hold WIDTH itself, so it needs one bit more than log2.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef YSYX_22041752_DIV_WORD_EN
  // Bit 31 as seen by the word helpers. It is clamped so that narrow builds
  // still elaborate; those builds never enable word mode.
  localparam int SB = (WIDTH > 32) ? 31 : WIDTH - 1;

  function automatic logic [WIDTH-1:0] sext_word(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = (i < 32) ? v[i] : v[SB];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] zext_word(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = (i < 32) ? v[i] : 1'b0;
    return r;
  endfunction
`else
  // The word port stays on the interface but has no effect in this build.
  logic unused_word;
  assign unused_word = word;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           state, state_next;
  logic [CW-1:0]    cnt;          // iterations still to run
  logic [WIDTH-1:0] dvd;          // |dividend| shifting out, quotient shifting in
  logic [WIDTH-1:0] rem;          // partial remainder
  logic [WIDTH-1:0] dvs;          // |divisor|
  logic             q_neg;        // negate the quotient at the end
  logic             r_neg;        // negate the remainder at the end
`ifdef YSYX_22041752_DIV_WORD_EN
  logic             word_q;       // latched word mode of the op in flight
`endif

  // --------------------------------------------------------------------------
  // Operand decode (used only on the handshake cycle)
  // --------------------------------------------------------------------------
  logic             word_eff;     // word op actually requested
  logic [WIDTH-1:0] a_ext, b_ext; // operands extended to the effective width
  logic [WIDTH-1:0] min_val;      // most-negative value of the effective width
  logic [WIDTH-1:0] a_res;        // dividend as a result (word: sign-extended)
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             div_zero, div_ovf;
  logic             hs;

  // NOTE: every signal driven from an always_comb gets a default value at the
  // top of the block. Otherwise, a path that skips an assignment would infer a
  // latch.
  always_comb begin
    word_eff = 1'b0;
    a_ext    = dividend;
    b_ext    = divisor;
    min_val  = MOST_NEG;
    a_res    = dividend;
`ifdef YSYX_22041752_DIV_WORD_EN
    if (word && (WIDTH == 64)) begin
      word_eff = 1'b1;
      a_ext    = div_signed ? sext_word(dividend) : zext_word(dividend);
      b_ext    = div_signed ? sext_word(divisor)  : zext_word(divisor);
      min_val  = sext_word(WIDTH'(32'h8000_0000));
      a_res    = sext_word(dividend);
    end
`endif
  end

  assign a_neg    = div_signed & a_ext[WIDTH-1];
  assign b_neg    = div_signed & b_ext[WIDTH-1];
  assign abs_a    = a_neg ? -a_ext : a_ext;
  assign abs_b    = b_neg ? -b_ext : b_ext;
  assign div_zero = (b_ext == '0);
  // The true result, -min_val, cannot be represented, so this case
  // short-circuits.
  assign div_ovf  = div_signed && (a_ext == min_val) && (b_ext == '1);
  assign hs       = in_valid && in_ready && !flush;

  // --------------------------------------------------------------------------
  // One restoring iteration: bring down the next dividend bit, try to
  // subtract |divisor|, and keep the old value if the subtraction would go
  // negative.
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   rem_sh;       // one bit wider: rem < dvs, so rem*2+1 fits
  logic             q_bit;
  logic [WIDTH-1:0] rem_nx, dvd_nx;
  logic [WIDTH-1:0] q_fin, r_fin;

  always_comb begin
    rem_sh = {rem, dvd[WIDTH-1]};
    q_bit  = (rem_sh >= {1'b0, dvs});
    rem_nx = q_bit ? WIDTH'(rem_sh - {1'b0, dvs}) : rem_sh[WIDTH-1:0];
    dvd_nx = {dvd[WIDTH-2:0], q_bit};
  end

  // Sign correction on the last iteration. The quotient takes the XOR of the
  // operand signs, and the remainder takes the dividend's sign.
  always_comb begin
    q_fin = q_neg ? -dvd_nx : dvd_nx;
    r_fin = r_neg ? -rem_nx : rem_nx;
`ifdef YSYX_22041752_DIV_WORD_EN
    // Word results are sign-extended from bit 31, the unsigned forms included.
    if (word_q) begin
      q_fin = sext_word(q_fin);
      r_fin = sext_word(r_fin);
    end
`endif
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments only. Every register
  // then updates from the values that were present before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (div_zero || div_ovf) ? DONE : CALC;
      end
      CALC: begin
        if (cnt == CW'(1)) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Flush overrides everything, including a same-cycle result handshake or
    // a new request.
    if (flush) state_next = IDLE;
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      dvd       <= '0;
      rem       <= '0;
      dvs       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef YSYX_22041752_DIV_WORD_EN
      word_q    <= 1'b0;
`endif
    end else if (flush) begin
      cnt <= '0;
    end else if (hs) begin
      rem   <= '0;
      dvs   <= abs_b;
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
      // For a word op, the 32 significant dividend bits are aligned to the
      // top of the shift register, so 32 shifts consume exactly those bits.
      dvd   <= word_eff ? (abs_a << (WIDTH / 2)) : abs_a;
      cnt   <= (div_zero || div_ovf) ? '0
             : (word_eff ? CW'(WIDTH / 2) : CW'(WIDTH));
`ifdef YSYX_22041752_DIV_WORD_EN
      word_q <= word_eff;
`endif
      if (div_zero) begin
        quotient  <= '1;
        remainder <= a_res;
      end else if (div_ovf) begin
        quotient  <= a_res;
        remainder <= '0;
      end
    end else if (state == CALC) begin
      cnt <= cnt - CW'(1);
      rem <= rem_nx;
      dvd <= dvd_nx;
      if (cnt == CW'(1)) begin
        quotient  <= q_fin;
        remainder <= r_fin;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041752_iter_div.sv
// ----------------------------------------------------------------------------
// Self-checking bench for ysyx_22041752_iter_div (WIDTH = 64).
//
// The bench applies three kinds of stimulus:
//   - a table of directed vectors with hand-derived results and latencies;
//   - randomized operations, checked against a plain-arithmetic reference
//     model;
//   - hand-written sequences for flush, output back-pressure and async reset.
// ----------------------------------------------------------------------------
module tb_ysyx_22041752_iter_div;

  localparam int W = 64;

`ifdef YSYX_22041752_DIV_WORD_EN
  localparam bit WORD_ON = 1'b1;
`else
  localparam bit WORD_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic         div_signed;
  logic         word;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_22041752_iter_div #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .div_signed (div_signed),
    .word       (word),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference model: the architectural definition expressed with the
  // language's own signed/unsigned 64-bit division.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input bit sgn,
                       input bit wd, output logic [63:0] q, output logic [63:0] r,
                       output int lat);
    logic [63:0] ea, eb;
    longint      sa, sb;
    bit          w;
    w   = wd && WORD_ON;
    ea  = w ? (sgn ? sx32(a[31:0]) : {32'd0, a[31:0]}) : a;
    eb  = w ? (sgn ? sx32(b[31:0]) : {32'd0, b[31:0]}) : b;
    lat = w ? 33 : 65;
    if (eb == 64'd0) begin
      q = '1; r = ea; lat = 1;
    end else if (sgn && eb == '1 &&
                 ea == (w ? sx32(32'h8000_0000) : 64'h8000_0000_0000_0000)) begin
      q = ea; r = 64'd0; lat = 1;
    end else if (sgn) begin
      sa = ea; sb = eb;
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = ea / eb;
      r = ea % eb;
    end
    if (w) begin
      q = sx32(q[31:0]);
      r = sx32(r[31:0]);
    end
  endtask

  // Full operation with out_ready held high: handshake, bounded wait for
  // out_valid, result and latency checks, then out_valid must drop.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input bit sgn,
                       input bit wd, input logic [63:0] q_exp, input logic [63:0] r_exp,
                       input int lat_exp, input string nm);
    int c;
    @(negedge clk);
    check({nm, ".in_ready"}, 64'(in_ready), 64'd1);
    dividend = a; divisor = b; div_signed = sgn; word = wd;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    c = 1;
    while (!out_valid && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check({nm, ".latency"}, 64'(c), 64'(lat_exp));
    check({nm, ".quotient"}, quotient, q_exp);
    check({nm, ".remainder"}, remainder, r_exp);
    @(posedge clk); #1;
    check({nm, ".valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    bit          sgn;
    bit          wd;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
    string       nm;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic [63:0] a, b, q, r;
    bit          sgn, wd;
    int          lat, c, rises, sel;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    div_signed = 1'b0; word = 1'b0; dividend = '0; divisor = '0;

    // ---------------- reset state ----------------
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready",  64'(in_ready),  64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.quotient",  quotient,       64'd0);
    check("rst.remainder", remainder,      64'd0);
    @(negedge clk);
    reset = 1'b1;

    // ---------------- directed vectors ----------------
    vecs.push_back('{64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65, "u100_7"});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65, "s_m7_2"});
    vecs.push_back('{64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65, "s_7_m2"});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0,
                     64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65, "s_m7_m2"});
    vecs.push_back('{64'd5, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1, "u5_0"});
    vecs.push_back('{64'd5, 64'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1, "s5_0"});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                     64'h8000_0000_0000_0000, 64'd0, 1, "s_ovf"});
    vecs.push_back('{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
                     64'd0, 64'h8000_0000_0000_0000, 65, "u_no_ovf"});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65, "umax_1"});
    vecs.push_back('{64'd3, 64'd10, 1'b0, 1'b0, 64'd0, 64'd3, 65, "small_by_big"});
`ifdef YSYX_22041752_DIV_WORD_EN
    vecs.push_back('{64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1,
                     64'hFFFF_FFFF_8000_0000, 64'd0, 1, "w_s_ovf"});
    vecs.push_back('{64'hFFFF_FFFF, 64'd1, 1'b0, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33, "w_u_max_1"});
    vecs.push_back('{64'h1234_5678_0000_0064, 64'hABCD_0000_0000_0007, 1'b0, 1'b1,
                     64'd14, 64'd2, 33, "w_u_upper_ignored"});
    vecs.push_back('{64'h0000_0001_FFFF_FFF9, 64'hFFFF_0000_0000_0002, 1'b1, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33, "w_s_m7_2"});
    vecs.push_back('{64'hDEAD_BEEF_8000_0005, 64'h1234_5678_0000_0000, 1'b0, 1'b1,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0005, 1, "w_u_div0"});
`else
    vecs.push_back('{64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1,
                     64'd0, 64'h8000_0000, 65, "w_s_ovf"});
    vecs.push_back('{64'hFFFF_FFFF, 64'd1, 1'b0, 1'b1,
                     64'hFFFF_FFFF, 64'd0, 65, "w_u_max_1"});
    vecs.push_back('{64'h1234_5678_0000_0064, 64'hABCD_0000_0000_0007, 1'b0, 1'b1,
                     64'd0, 64'h1234_5678_0000_0064, 65, "w_u_upper_ignored"});
    vecs.push_back('{64'h0000_0001_FFFF_FFF9, 64'hFFFF_0000_0000_0002, 1'b1, 1'b1,
                     64'd0, 64'h0000_0001_FFFF_FFF9, 65, "w_s_m7_2"});
    vecs.push_back('{64'hDEAD_BEEF_8000_0005, 64'h1234_5678_0000_0000, 1'b0, 1'b1,
                     64'd12, 64'h0439_B14F_8000_0005, 65, "w_u_div0"});
`endif

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].wd,
            vecs[i].q, vecs[i].r, vecs[i].lat, vecs[i].nm);

    // ---------------- randomized against the model ----------------
    for (int i = 0; i < 40; i++) begin
      a   = {$urandom, $urandom} >> $urandom_range(0, 40);
      b   = {$urandom, $urandom} >> $urandom_range(0, 63);
      sel = $urandom_range(0, 15);
      if (sel == 0) b = 64'd0;
      else if (sel == 1) begin
        a = 64'h8000_0000_0000_0000; b = '1;
      end else if (sel == 2) begin
        a = {$urandom, 32'h8000_0000}; b = {$urandom, 32'hFFFF_FFFF};
      end else if (sel == 3) begin
        b = {$urandom, 32'd0};
      end
      sgn = 1'($urandom_range(0, 1));
      wd  = 1'($urandom_range(0, 1));
      model(a, b, sgn, wd, q, r, lat);
      do_op(a, b, sgn, wd, q, r, lat, $sformatf("rnd%0d", i));
    end

    // ---------------- flush in CALC cycle 10 ----------------
    @(negedge clk);
    dividend = 64'd100; divisor = 64'd7; div_signed = 1'b0; word = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;                 // cycle 1
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end   // cycle 10
    flush = 1'b1;
    in_valid = 1'b1;                    // must not be taken
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_calc.in_ready",  64'(in_ready),  64'd1);
    check("flush_calc.out_valid", 64'(out_valid), 64'd0);
    rises = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) rises++;
    end
    check("flush_calc.no_result", 64'(rises), 64'd0);

    // A request presented together with flush in IDLE is not accepted.
    @(negedge clk);
    dividend = 64'd5; divisor = 64'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle.in_ready",  64'(in_ready),  64'd1);
    check("flush_idle.out_valid", 64'(out_valid), 64'd0);

    // Flush together with out_ready in DONE drops the result.
    @(negedge clk);
    dividend = 64'd9; divisor = 64'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("flush_done.pre_valid", 64'(out_valid), 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_done.out_valid", 64'(out_valid), 64'd0);
    check("flush_done.in_ready",  64'(in_ready),  64'd1);

    // ---------------- back-pressure in DONE ----------------
    model(64'd100, 64'd7, 1'b0, 1'b0, q, r, lat);
    @(negedge clk);
    dividend = 64'd100; divisor = 64'd7; div_signed = 1'b0; word = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    c = 1;
    while (!out_valid && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check("hold.latency", 64'(c), 64'(lat));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d.out_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("hold%0d.in_ready", k),  64'(in_ready),  64'd0);
      check($sformatf("hold%0d.quotient", k),  quotient,  q);
      check($sformatf("hold%0d.remainder", k), remainder, r);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold.release_valid", 64'(out_valid), 64'd0);
    check("hold.release_ready", 64'(in_ready),  64'd1);

    // ---------------- async reset mid-CALC ----------------
    @(negedge clk);
    dividend = 64'd1000; divisor = 64'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    #3 reset = 1'b0;                    // between clock edges
    #1;
    check("arst.in_ready",  64'(in_ready),  64'd1);
    check("arst.out_valid", 64'(out_valid), 64'd0);
    check("arst.quotient",  quotient,       64'd0);
    check("arst.remainder", remainder,      64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Normal operation after the reset.
    model(64'd1000, 64'd3, 1'b0, 1'b0, q, r, lat);
    do_op(64'd1000, 64'd3, 1'b0, 1'b0, q, r, lat, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041752_iter_div.md
# ysyx_22041752_iter_div

Parametrised, multi-cycle radix-2 restoring divider with a valid/ready handshake on both sides, signed/unsigned modes, an RV64 word mode and a flush. It replaces the single-cycle divider behind the ALU's `op_div`/`op_rem` path. The execute stage stalls on `out_valid` and drops in-flight work on pipeline flush. Both quotient and remainder come from one operation.

## Interface
- `WIDTH`, 64, operand/result width; even, ≥8.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous abort of any operation in progress.
- `in_valid` in 1: request valid.
- `in_ready` out 1: divider idle; high only in IDLE.
- `div_signed` in 1: 1 = signed (DIV/REM), 0 = unsigned; sampled at handshake.
- `word` in 1: 1 = 32-bit op (DIVW/DIVUW/REMW/REMUW); sampled at handshake.
- `dividend` in WIDTH: numerator.
- `divisor` in WIDTH: denominator.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `quotient` out WIDTH: quotient, registered.
- `remainder` out WIDTH: remainder, registered.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: `in_ready`=1. Handshake (`in_valid & in_ready & !flush`) latches operands, mode and `word`.
  - Divisor == 0 → DONE. Quotient = all ones; remainder = dividend (effective width).
  - Signed, dividend = most-negative, divisor = −1 → DONE. Quotient = dividend; remainder = 0.
  - Otherwise → CALC with iteration counter = N. N = 32 if `word`, else WIDTH.
- CALC: takes absolute values when signed. Each cycle shifts one quotient bit in: partial remainder − |divisor|, restore if negative. Counter decrements each cycle. The last iteration applies sign correction and registers results, then → DONE.
  - Quotient is negated iff signed and operand signs differ.
  - Remainder takes the dividend's sign.
- DONE: `out_valid`=1. `quotient`/`remainder` stay stable while `out_ready`=0. On `out_valid & out_ready` → IDLE; `out_valid` drops next cycle.
- Word mode: operands are the low 32 bits, sign-extended if `div_signed`, else zero-extended. Both results are sign-extended from bit 31, including the unsigned forms. The overflow case uses 32-bit values. Word mode is legal only with WIDTH=64; otherwise it is tied 0.
- Flush: any state → IDLE on the next edge. `out_valid`=0 from then on. Results are discarded. A request presented in the flush cycle is not accepted.

## Timing
- Reset (asserted `reset`=0):
  - State = IDLE.
  - `in_ready`=1.
  - `out_valid`=0.
  - `quotient`=0.
  - `remainder`=0.
  - Counter = 0.
- Reset mid-operation aborts immediately, asynchronously.
- Normal latency: a handshake in cycle 0 gives `out_valid` in cycle N+1. That is 65 cycles for 64-bit ops and 33 for word ops.
- Special-case latency (divide-by-zero, overflow): `out_valid` in cycle 1.
- Throughput: one op per N+2 cycles minimum. There is no acceptance in DONE; the next handshake is possible in the cycle after the result handshake.
- `in_ready` is a pure function of state.
- No combinational path from `in_valid` to `out_valid`, or from `out_ready` to `in_ready`.
- Flush and `out_ready` in the same DONE cycle: flush wins, and the result counts as not consumed.

## Configuration
- `YSYX_22041752_DIV_WORD_EN` defined:
  - Word mode is implemented as described.
  - N = 32 for word ops.
- Not defined:
  - The `word` port remains but is ignored and treated as 0.
  - There is no 32-bit extension/overflow logic.
  - All ops take N = WIDTH.

## Test plan
- Unsigned, 64-bit, 100 / 7 → quotient 14, remainder 2; `out_valid` exactly 65 cycles after the handshake.
- Signed: −7 / 2 → quotient 0xFFFF_FFFF_FFFF_FFFD, remainder 0xFFFF_FFFF_FFFF_FFFF. Signed: 7 / −2 → quotient −3, remainder 1.
- 5 / 0 in both signed and unsigned modes → quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 5; `out_valid` 1 cycle after the handshake.
- Signed 0x8000_0000_0000_0000 / −1 → quotient 0x8000_0000_0000_0000, remainder 0, latency 1.
  - With the macro: word signed 0x8000_0000 / 0xFFFF_FFFF → quotient 0xFFFF_FFFF_8000_0000, remainder 0.
- With the macro: word unsigned 0xFFFF_FFFF / 1 → quotient 0xFFFF_FFFF_FFFF_FFFF (sign-extended), remainder 0, latency 33. Without the macro: the same stimulus → quotient 0xFFFF_FFFF, latency 65.
- Control sequence:
  - Flush in CALC cycle 10 → `out_valid` never rises; `in_ready`=1 next cycle.
  - Then hold `out_ready`=0 for 5 cycles in DONE → outputs constant; release → IDLE next cycle.
  - Async reset asserted mid-CALC → all outputs at reset values immediately.
